// File: rtl/mul_batch_engine.sv
// Batch multiplier: reads 512-bit operand lines, multiplies LANES pairs in parallel and writes results plus a status line.
// Optional define MUL_BATCH_OVERFLOW_FLAG_EN adds per-lane overflow bits above the packed results.
module mul_batch_engine #(
    parameter int DATA_LEN       = 32,
    parameter int LANES          = 8,
    parameter int PIPELINE_STAGE = 2,
    parameter int ADDR_W         = 42,
    parameter int CNT_W          = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] in_base,
    input  logic [ADDR_W-1:0] out_base,
    input  logic [CNT_W-1:0]  num_lines,
    output logic              rd_req_valid,
    output logic [ADDR_W-1:0] rd_req_addr,
    input  logic              rd_req_ready,
    input  logic              rd_rsp_valid,
    input  logic [511:0]      rd_rsp_data,
    output logic              wr_req_valid,
    output logic [ADDR_W-1:0] wr_req_addr,
    output logic [511:0]      wr_req_data,
    input  logic              wr_req_ready,
    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  lines_done
);
    localparam int LINE_W = 512;
    localparam int CNT_PW = $clog2(PIPELINE_STAGE + 1);

    typedef enum logic [2:0] {IDLE, RD_REQ, RD_WAIT, COMPUTE, WR_REQ, STATUS, DONE} state_t;

    state_t                             state_reg;
    logic [ADDR_W-1:0]                  in_base_reg, out_base_reg;
    logic [CNT_W-1:0]                   num_lines_reg, lines_done_reg, lines_done_next;
    logic [LANES-1:0][DATA_LEN-1:0]     a_reg, b_reg, prod_lo;
    logic [PIPELINE_STAGE-1:0][LINE_W-1:0] pipe_reg;
    logic [LINE_W-1:0]                  product_line, status_line;
    logic [CNT_PW-1:0]                  cnt_reg;
    logic                               rd_req_valid_reg, wr_req_valid_reg, done_reg, busy_reg;
    logic [ADDR_W-1:0]                  rd_req_addr_reg, wr_req_addr_reg;

`ifdef MUL_BATCH_OVERFLOW_FLAG_EN
    logic [LANES-1:0] prod_ovf;
`endif

    generate
        for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
`ifdef MUL_BATCH_OVERFLOW_FLAG_EN
            logic [2*DATA_LEN-1:0] full_prod;
            assign full_prod   = {{DATA_LEN{1'b0}}, a_reg[gi]} * {{DATA_LEN{1'b0}}, b_reg[gi]};
            assign prod_lo[gi] = full_prod[DATA_LEN-1:0];
            assign prod_ovf[gi] = |full_prod[2*DATA_LEN-1:DATA_LEN];
`else
            assign prod_lo[gi] = a_reg[gi] * b_reg[gi];
`endif
        end
    endgenerate

    always_comb begin
        product_line = '0;
        for (int i = 0; i < LANES; i++) begin
            product_line[i*DATA_LEN +: DATA_LEN] = prod_lo[i];
`ifdef MUL_BATCH_OVERFLOW_FLAG_EN
            product_line[LANES*DATA_LEN + i] = prod_ovf[i];
`endif
        end
    end

    always_comb begin
        status_line        = '0;
        status_line[31:0]  = 32'd1;
        status_line[63:32] = 32'(num_lines_reg);
    end

    assign lines_done_next = lines_done_reg + 1'b1;

    // Pipeline free-runs; operands only change on a read capture, so the tail stays stable while a write stalls.
    always_ff @(posedge clk) begin
        if (reset) begin
            pipe_reg <= '0;
        end else begin
            for (int s = PIPELINE_STAGE - 1; s > 0; s--)
                pipe_reg[s] <= pipe_reg[s-1];
            pipe_reg[0] <= product_line;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg        <= IDLE;
            in_base_reg      <= '0;
            out_base_reg     <= '0;
            num_lines_reg    <= '0;
            lines_done_reg   <= '0;
            a_reg            <= '0;
            b_reg            <= '0;
            cnt_reg          <= '0;
            rd_req_valid_reg <= 1'b0;
            rd_req_addr_reg  <= '0;
            wr_req_valid_reg <= 1'b0;
            wr_req_addr_reg  <= '0;
            done_reg         <= 1'b0;
            busy_reg         <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: if (start) begin
                    in_base_reg    <= in_base;
                    out_base_reg   <= out_base;
                    num_lines_reg  <= num_lines;
                    lines_done_reg <= '0;
                    busy_reg       <= 1'b1;
                    if (num_lines == '0) begin
                        wr_req_valid_reg <= 1'b1;
                        wr_req_addr_reg  <= out_base;
                        state_reg        <= STATUS;
                    end else begin
                        rd_req_valid_reg <= 1'b1;
                        rd_req_addr_reg  <= in_base;
                        state_reg        <= RD_REQ;
                    end
                end
                RD_REQ: if (rd_req_ready) begin
                    rd_req_valid_reg <= 1'b0;
                    state_reg        <= RD_WAIT;
                end
                RD_WAIT: if (rd_rsp_valid) begin
                    for (int i = 0; i < LANES; i++) begin
                        a_reg[i] <= rd_rsp_data[2*i*DATA_LEN +: DATA_LEN];
                        b_reg[i] <= rd_rsp_data[(2*i+1)*DATA_LEN +: DATA_LEN];
                    end
                    cnt_reg   <= '0;
                    state_reg <= COMPUTE;
                end
                COMPUTE: begin
                    if (cnt_reg == CNT_PW'(PIPELINE_STAGE - 1)) begin
                        wr_req_valid_reg <= 1'b1;
                        wr_req_addr_reg  <= out_base_reg + ADDR_W'(lines_done_reg);
                        state_reg        <= WR_REQ;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                WR_REQ: if (wr_req_ready) begin
                    lines_done_reg <= lines_done_next;
                    if (lines_done_next < num_lines_reg) begin
                        wr_req_valid_reg <= 1'b0;
                        rd_req_valid_reg <= 1'b1;
                        rd_req_addr_reg  <= in_base_reg + ADDR_W'(lines_done_next);
                        state_reg        <= RD_REQ;
                    end else begin
                        wr_req_addr_reg <= out_base_reg + ADDR_W'(num_lines_reg);
                        state_reg       <= STATUS;
                    end
                end
                STATUS: if (wr_req_ready) begin
                    wr_req_valid_reg <= 1'b0;
                    done_reg         <= 1'b1;
                    state_reg        <= DONE;
                end
                DONE: begin
                    done_reg  <= 1'b0;
                    busy_reg  <= 1'b0;
                    state_reg <= IDLE;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign rd_req_valid = rd_req_valid_reg;
    assign rd_req_addr  = rd_req_addr_reg;
    assign wr_req_valid = wr_req_valid_reg;
    assign wr_req_addr  = wr_req_addr_reg;
    assign wr_req_data  = (state_reg == STATUS) ? status_line : pipe_reg[PIPELINE_STAGE-1];
    assign busy         = busy_reg;
    assign done         = done_reg;
    assign lines_done   = lines_done_reg;
endmodule
